// File: rtl/pipe_ctrl_chain_pkg.sv
// Shared control-bundle layout for the decode-to-writeback control pipeline.
// Field order matches the decoder output word, ALUControl in the low bits.
package pipe_pkg;

    localparam int CTRL_W = 13;

    localparam int ALU_CTRL_LSB   = 0;
    localparam int ALU_CTRL_W     = 5;
    localparam int RESULT_SRC_LSB = 5;
    localparam int RESULT_SRC_W   = 2;
    localparam int ALU_SRC_B_LSB  = 7;
    localparam int ALU_SRC_B_W    = 1;
    localparam int ALU_SRC_A_LSB  = 8;
    localparam int ALU_SRC_A_W    = 1;
    localparam int BRANCH_LSB     = 9;
    localparam int BRANCH_W       = 1;
    localparam int JUMP_LSB       = 10;
    localparam int JUMP_W         = 1;
    localparam int MEM_WRITE_LSB  = 11;
    localparam int MEM_WRITE_W    = 1;
    localparam int REG_WRITE_LSB  = 12;
    localparam int REG_WRITE_W    = 1;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [1:0] result_src;
        logic [4:0] alu_control;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_ctrl_chain_if.sv
// Handshake/bus bundle between the hazard unit/decoder (master) and the control chain (slave).
interface pipe_ctrl_chain_if #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 1,
    parameter int CNT_W = 16
);
    logic [DEPTH-1:0] en;
    logic [DEPTH-1:0] clr;
    logic             in_valid;
    logic [WIDTH-1:0] in_ctrl;
    logic             cnt_clr;
    logic             out_valid;
    logic [WIDTH-1:0] out_ctrl;
    logic [DEPTH-1:0] stage_valid;
    logic             overrun;
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output en, clr, in_valid, in_ctrl, cnt_clr,
        input  out_valid, out_ctrl, stage_valid, overrun, bubble_cnt, flush_cnt
    );

    modport slave (
        input  en, clr, in_valid, in_ctrl, cnt_clr,
        output out_valid, out_ctrl, stage_valid, overrun, bubble_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl_chain_slice.sv
// One control-register stage: flush beats stall beats load; loads a bubble when upstream is stalled.
// Stage 0 ties up_en_i high so it always takes the decoder bundle when enabled.
module pipe_ctrl_slice #(
    parameter int               WIDTH   = 13,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             up_en_i,
    input  logic             up_valid_i,
    input  logic [WIDTH-1:0] up_ctrl_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] ctrl_o
);
    logic [WIDTH-1:0] ctrl_q;
    logic             valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= RST_VAL;
            valid_q <= 1'b0;
        end else if (clr_i) begin
            ctrl_q  <= RST_VAL;
            valid_q <= 1'b0;
        end else if (en_i) begin
            // A stalled upstream keeps its entry, so take a bubble instead of a copy.
            if (up_en_i) begin
                ctrl_q  <= up_ctrl_i;
                valid_q <= up_valid_i;
            end else begin
                ctrl_q  <= RST_VAL;
                valid_q <= 1'b0;
            end
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
endmodule

// File: rtl/pipe_ctrl_chain.sv
// DEPTH-stage control register chain with per-stage stall/flush, sticky overrun flag and
// saturating bubble/flush performance counters. All outputs come straight from registers.
module pipe_ctrl_chain
    import pipe_pkg::*;
#(
    parameter int               WIDTH   = CTRL_W,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(CTRL_NOP),
    parameter int               CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_ctrl_chain_if.slave   bus
);
    // Wide enough for counter + popcount of up to 8 stages without overflow.
    localparam int SUM_W = ((CNT_W > 4) ? CNT_W : 4) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [WIDTH-1:0] ctrl_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             up_en;
        logic             up_valid;
        logic [WIDTH-1:0] up_ctrl;

        if (g == 0) begin : g_head
            assign up_en    = 1'b1;
            assign up_valid = bus.in_valid;
            assign up_ctrl  = bus.in_ctrl;
        end else begin : g_body
            assign up_en    = bus.en[g-1];
            assign up_valid = valid_q[g-1];
            assign up_ctrl  = ctrl_q[g-1];
        end

        pipe_ctrl_slice #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_slice (
            .clk        (clk),
            .rst_n      (rst_n),
            .en_i       (bus.en[g]),
            .clr_i      (bus.clr[g]),
            .up_en_i    (up_en),
            .up_valid_i (up_valid),
            .up_ctrl_i  (up_ctrl),
            .valid_o    (valid_q[g]),
            .ctrl_o     (ctrl_q[g])
        );
    end

    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             ovr_hit;
    logic [3:0]       flush_inc;
    logic [SUM_W-1:0] flush_sum;

    always_comb begin
        ovr_hit   = 1'b0;
        flush_inc = 4'd0;
        for (int i = 1; i < DEPTH; i++) begin
            // Upstream moves a live entry into a held stage: that entry is overwritten.
            if (!bus.en[i] && !bus.clr[i] && bus.en[i-1] && !bus.clr[i-1] && valid_q[i-1])
                ovr_hit = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++)
            flush_inc = flush_inc + {3'd0, bus.clr[i] & valid_q[i]};
    end

    always_comb begin
        overrun_d = overrun_q | ovr_hit;
        flush_sum = SUM_W'(flush_q) + SUM_W'(flush_inc);
        bubble_d  = bubble_q;
        flush_d   = flush_q;
        if (bus.cnt_clr) begin
            bubble_d = '0;
            flush_d  = '0;
        end else begin
            if (!valid_q[DEPTH-1] && (bubble_q != {CNT_W{1'b1}}))
                bubble_d = bubble_q + 1'b1;
            flush_d = (flush_sum > CNT_MAX) ? {CNT_W{1'b1}} : flush_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
            bubble_q  <= '0;
            flush_q   <= '0;
        end else begin
            overrun_q <= overrun_d;
            bubble_q  <= bubble_d;
            flush_q   <= flush_d;
        end
    end

    assign bus.out_valid   = valid_q[DEPTH-1];
    assign bus.out_ctrl    = ctrl_q[DEPTH-1];
    assign bus.stage_valid = valid_q;
    assign bus.overrun     = overrun_q;
    assign bus.bubble_cnt  = bubble_q;
    assign bus.flush_cnt   = flush_q;
endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Directed bench: a 3-deep chain for streaming/async reset, a 2-deep chain with 4-bit counters
// for stall, flush, overrun and saturation.
module tb_pipe_ctrl_chain;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    pipe_ctrl_chain_if #(.WIDTH(13), .DEPTH(3), .CNT_W(16)) if3 ();
    pipe_ctrl_chain_if #(.WIDTH(13), .DEPTH(2), .CNT_W(4))  if2 ();

    pipe_ctrl_chain #(.WIDTH(13), .DEPTH(3), .RST_VAL(13'h0), .CNT_W(16)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if3)
    );

    pipe_ctrl_chain #(.WIDTH(13), .DEPTH(2), .RST_VAL(13'h0), .CNT_W(4)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        if3.en = '0; if3.clr = '0; if3.in_valid = 1'b0; if3.in_ctrl = '0; if3.cnt_clr = 1'b0;
        if2.en = '0; if2.clr = '0; if2.in_valid = 1'b0; if2.in_ctrl = '0; if2.cnt_clr = 1'b0;

        tick();
        chk("rst3_svalid", 32'(if3.stage_valid), 32'h0);
        chk("rst3_octrl",  32'(if3.out_ctrl),    32'h0);
        chk("rst3_bubble", 32'(if3.bubble_cnt),  32'h0);
        chk("rst2_ovr",    32'(if2.overrun),     32'h0);
        chk("rst2_flush",  32'(if2.flush_cnt),   32'h0);
        rst_n = 1'b1;

        // Streaming through three stages
        if3.en = 3'b111; if3.in_valid = 1'b1; if3.in_ctrl = 13'h001;
        tick();
        chk("str_sv1", 32'(if3.stage_valid), 32'h1);
        if3.in_ctrl = 13'h002;
        tick();
        if3.in_ctrl = 13'h003;
        tick();
        chk("str_o1",  32'(if3.out_ctrl),  32'h001);
        chk("str_v1",  32'(if3.out_valid), 32'h1);
        if3.in_valid = 1'b0; if3.in_ctrl = 13'h000;
        tick();
        chk("str_o2",  32'(if3.out_ctrl), 32'h002);
        tick();
        chk("str_o3",  32'(if3.out_ctrl),   32'h003);
        chk("str_bub", 32'(if3.bubble_cnt), 32'd3);
        tick();
        chk("str_vend", 32'(if3.out_valid), 32'h0);

        // Counter clear with a bubble in the same cycle, then saturation
        if2.cnt_clr = 1'b1;
        tick();
        chk("cclr_bub",   32'(if2.bubble_cnt), 32'h0);
        chk("cclr_flush", 32'(if2.flush_cnt),  32'h0);
        if2.cnt_clr = 1'b0;
        repeat (20) tick();
        chk("sat_bub", 32'(if2.bubble_cnt), 32'd15);
        if2.cnt_clr = 1'b1;
        tick();
        chk("sat_clr", 32'(if2.bubble_cnt), 32'h0);
        if2.cnt_clr = 1'b0;

        // Stall with bubble insertion
        if2.en = 2'b01; if2.in_valid = 1'b1; if2.in_ctrl = 13'h0AA;
        tick();
        chk("stl_load", 32'(if2.stage_valid), 32'h1);
        if2.en = 2'b10; if2.in_valid = 1'b0; if2.in_ctrl = 13'h0;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("stl_sv",   32'(if2.stage_valid), 32'h1);
            chk("stl_octl", 32'(if2.out_ctrl),    32'h0);
        end
        if2.en = 2'b11;
        tick();
        chk("stl_rel_o", 32'(if2.out_ctrl),  32'h0AA);
        chk("stl_rel_v", 32'(if2.out_valid), 32'h1);
        tick();
        chk("stl_once", 32'(if2.out_valid), 32'h0);

        // Flush wins over enable; downstream takes pre-flush contents
        if2.en = 2'b01; if2.in_valid = 1'b1; if2.in_ctrl = 13'h055;
        tick();
        if2.clr = 2'b01; if2.en = 2'b11; if2.in_ctrl = 13'h077;
        tick();
        chk("fl_sv",    32'(if2.stage_valid), 32'h2);
        chk("fl_octl",  32'(if2.out_ctrl),    32'h055);
        chk("fl_cnt",   32'(if2.flush_cnt),   32'd1);
        chk("fl_noovr", 32'(if2.overrun),     32'h0);
        if2.clr = 2'b00;

        // Overrun: valid stage 0 advancing into held stage 1
        if2.en = 2'b01; if2.in_valid = 1'b1; if2.in_ctrl = 13'h011;
        tick();
        chk("ovr_pre", 32'(if2.overrun), 32'h0);
        if2.in_valid = 1'b0; if2.in_ctrl = 13'h0;
        tick();
        chk("ovr_set",  32'(if2.overrun),  32'h1);
        chk("ovr_hold", 32'(if2.out_ctrl), 32'h055);
        if2.en = 2'b11;
        tick();
        chk("ovr_stick", 32'(if2.overrun), 32'h1);

        // Async reset between edges with the 3-deep chain full
        if3.en = 3'b111; if3.in_valid = 1'b1;
        for (int k = 4; k <= 6; k++) begin
            if3.in_ctrl = 13'(k);
            tick();
        end
        chk("ar_full", 32'(if3.stage_valid), 32'h7);
        chk("ar_out",  32'(if3.out_ctrl),    32'h004);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_sv",   32'(if3.stage_valid), 32'h0);
        chk("ar_octl", 32'(if3.out_ctrl),    32'h0);
        chk("ar_ov",   32'(if3.out_valid),   32'h0);
        chk("ar_ovr",  32'(if2.overrun),     32'h0);
        chk("ar_bub",  32'(if2.bubble_cnt),  32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
